mpx_writeback: RTL

- Writeback stage feeding the MPX core's single-write-port register file.
- Merges in-order ALU/exec results and late-returning load data into one registered write (rd0/rd0_value).
- Tracks outstanding loads for hazard detection and enforces R3000 load-delay write-after-write ordering.
- Sits between the execute/LSU stages and the register file.

---
 rtl/mpx_writeback.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/mpx_writeback.sv
// mpx_writeback: writeback stage for the MPX core's single-write-port register file.
//
// Merges in-order exec results and late-returning load data into one registered
// register file write (rd0_o / rd0_value_o). It keeps a small FIFO of outstanding
// loads ({rd, kill}) so that hazards can be detected and load-delay write-after-write
// ordering is preserved. A younger exec write to the same rd kills the older load.
//
// Parameters:
//   LOAD_DEPTH   outstanding load entries (power of two, >= 2)
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   flush_i                      exception flush, discards all pending state
//   exec_valid_i/rd_i/value_i    in-order exec result
//   load_issue_i/load_rd_i       load issued to the LSU
//   mem_valid_i/mem_value_i      load data return, in issue order
//   stall_o                      upstream must not present new exec or load
//   rd0_o/rd0_value_o            register file write (rd0_o == 0 means no write)
//   pending_o/pending_rd_o       oldest live outstanding load
//   ra_*/rb_*                    operand bypass ports, present only with
//                                MPX_WB_BYPASS_EN defined
//
// Optional feature macro: MPX_WB_BYPASS_EN (forwards rd0 onto ra/rb read data).

module mpx_writeback #(
    parameter int LOAD_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        exec_valid_i,
    input  logic [4:0]  exec_rd_i,
    input  logic [31:0] exec_value_i,
    input  logic        load_issue_i,
    input  logic [4:0]  load_rd_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_value_i,
    output logic        stall_o,
    output logic [4:0]  rd0_o,
    output logic [31:0] rd0_value_o,
    output logic        pending_o,
    output logic [4:0]  pending_rd_o
`ifdef MPX_WB_BYPASS_EN
    ,
    input  logic [4:0]  ra_i,
    input  logic [4:0]  rb_i,
    input  logic [31:0] ra_value_i,
    input  logic [31:0] rb_value_i,
    output logic [31:0] ra_value_o,
    output logic [31:0] rb_value_o
`endif
);

    localparam int PW = $clog2(LOAD_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(LOAD_DEPTH);
    localparam logic [CW-1:0] NEAR_CNT = CW'(LOAD_DEPTH - 1);

    logic [LOAD_DEPTH-1:0]      ent_valid_q, ent_valid_d;
    logic [LOAD_DEPTH-1:0]      ent_kill_q, ent_kill_d;
    logic [LOAD_DEPTH-1:0][4:0] ent_rd_q, ent_rd_d;
    logic [PW-1:0]              head_q, head_d;
    logic [PW-1:0]              tail_q, tail_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       skid_valid_q, skid_valid_d;
    logic [4:0]                 skid_rd_q, skid_rd_d;
    logic [31:0]                skid_value_q, skid_value_d;
    logic                       issue_prev_q, issue_prev_d;
    logic [4:0]                 rd0_q, rd0_d;
    logic [31:0]                rd0_value_q, rd0_value_d;

    logic                       pop;
    logic                       load_wr;
    logic                       exec_wr;
    logic [4:0]                 head_rd;
    logic                       pend_found;
    logic [4:0]                 pend_rd;
    logic [PW-1:0]              scan_idx;

    always_comb begin
        ent_valid_d  = ent_valid_q;
        ent_kill_d   = ent_kill_q;
        ent_rd_d     = ent_rd_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        skid_valid_d = skid_valid_q;
        skid_rd_d    = skid_rd_q;
        skid_value_d = skid_value_q;
        issue_prev_d = 1'b0;
        rd0_d        = 5'd0;
        rd0_value_d  = rd0_value_q;

        // mem_valid_i against an empty FIFO is a protocol error and is ignored
        pop     = mem_valid_i && (count_q != '0);
        head_rd = ent_rd_q[head_q];
        load_wr = pop && !ent_kill_q[head_q] && (head_rd != 5'd0);
        // an exec result to r0 is not a write: it neither kills nor uses the port
        exec_wr = exec_valid_i && (exec_rd_i != 5'd0);

        if (flush_i) begin
            ent_valid_d  = '0;
            ent_kill_d   = '0;
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            skid_valid_d = 1'b0;
        end else begin
            // load data owns the port; exec parks in the skid if it cannot go out
            if (load_wr) begin
                rd0_d       = head_rd;
                rd0_value_d = mem_value_i;
                if (!skid_valid_q && exec_wr) begin
                    skid_valid_d = 1'b1;
                    skid_rd_d    = exec_rd_i;
                    skid_value_d = exec_value_i;
                end
            end else if (skid_valid_q) begin
                rd0_d        = skid_rd_q;
                rd0_value_d  = skid_value_q;
                skid_valid_d = exec_wr;
                skid_rd_d    = exec_rd_i;
                skid_value_d = exec_value_i;
            end else if (exec_wr) begin
                rd0_d       = exec_rd_i;
                rd0_value_d = exec_value_i;
            end

            // kills apply to existing entries only; the push below is younger
            // than nothing here and is written with kill clear afterwards
            for (int i = 0; i < LOAD_DEPTH; i++) begin
                if (exec_wr && ent_valid_q[i] && (ent_rd_q[i] == exec_rd_i)) begin
                    ent_kill_d[i] = 1'b1;
                end
            end

            if (pop) begin
                ent_valid_d[head_q] = 1'b0;
                ent_kill_d[head_q]  = 1'b0;
                head_d              = head_q + 1'b1;
            end

            if (load_issue_i) begin
                ent_valid_d[tail_q] = 1'b1;
                ent_kill_d[tail_q]  = 1'b0;
                ent_rd_d[tail_q]    = load_rd_i;
                tail_d              = tail_q + 1'b1;
            end

            issue_prev_d = load_issue_i;
            if (load_issue_i && !pop) begin
                count_d = count_q + 1'b1;
            end else if (!load_issue_i && pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // oldest live load: scan from head in issue order
    always_comb begin
        pend_found = 1'b0;
        pend_rd    = 5'd0;
        scan_idx   = head_q;
        for (int k = 0; k < LOAD_DEPTH; k++) begin
            scan_idx = head_q + PW'(k);
            if (!pend_found && ent_valid_q[scan_idx] && !ent_kill_q[scan_idx]
                && (ent_rd_q[scan_idx] != 5'd0)) begin
                pend_found = 1'b1;
                pend_rd    = ent_rd_q[scan_idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ent_valid_q  <= '0;
            ent_kill_q   <= '0;
            ent_rd_q     <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            skid_valid_q <= 1'b0;
            skid_rd_q    <= 5'd0;
            skid_value_q <= 32'd0;
            issue_prev_q <= 1'b0;
            rd0_q        <= 5'd0;
            rd0_value_q  <= 32'd0;
        end else begin
            ent_valid_q  <= ent_valid_d;
            ent_kill_q   <= ent_kill_d;
            ent_rd_q     <= ent_rd_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            skid_valid_q <= skid_valid_d;
            skid_rd_q    <= skid_rd_d;
            skid_value_q <= skid_value_d;
            issue_prev_q <= issue_prev_d;
            rd0_q        <= rd0_d;
            rd0_value_q  <= rd0_value_d;
        end
    end

    // a load issued last cycle is already counted, so one free slot is not enough
    assign stall_o = skid_valid_q || (count_q == FULL_CNT)
                     || ((count_q == NEAR_CNT) && issue_prev_q);

    assign rd0_o        = rd0_q;
    assign rd0_value_o  = rd0_value_q;
    assign pending_o    = pend_found;
    assign pending_rd_o = pend_rd;

`ifdef MPX_WB_BYPASS_EN
    assign ra_value_o = ((ra_i == rd0_q) && (rd0_q != 5'd0)) ? rd0_value_q : ra_value_i;
    assign rb_value_o = ((rb_i == rd0_q) && (rd0_q != 5'd0)) ? rd0_value_q : rb_value_i;
`endif

endmodule
